// File: rtl/clint_pkg.sv
// clint_pkg: constants and helpers shared by the CLINT timer and the CSR block.
//   - Register offsets relative to the CLINT base address.
//   - mip bit indices for the machine-level interrupt sources.
//   - Register-select enum and address decoder used by the bus logic.
package clint_pkg;

  // Register offsets from BASE_ADDR
  localparam logic [31:0] CLINT_MSIP        = 32'h0000_0000;
  localparam logic [31:0] CLINT_MTIMECMP_LO = 32'h0000_4000;
  localparam logic [31:0] CLINT_MTIMECMP_HI = 32'h0000_4004;
  localparam logic [31:0] CLINT_MTIME_LO    = 32'h0000_BFF8;
  localparam logic [31:0] CLINT_MTIME_HI    = 32'h0000_BFFC;

  // mip bit positions, shared with the CSR block
  localparam int unsigned MIP_MSIP = 3;
  localparam int unsigned MIP_MTIP = 7;
  localparam int unsigned MIP_MEIP = 11;

  // Decoded register select
  typedef enum logic [2:0] {
    RegNone,
    RegMsip,
    RegCmpLo,
    RegCmpHi,
    RegTimeLo,
    RegTimeHi
  } clint_reg_e;

  // Map a bus byte address to a register select; anything unmapped (including
  // addresses below the base, which wrap to huge offsets) decodes to RegNone.
  function automatic clint_reg_e clint_decode(input logic [31:0] addr,
                                              input logic [31:0] base);
    logic [31:0] off;
    clint_reg_e  sel;
    off = addr - base;
    case (off)
      CLINT_MSIP:        sel = RegMsip;
      CLINT_MTIMECMP_LO: sel = RegCmpLo;
      CLINT_MTIMECMP_HI: sel = RegCmpHi;
      CLINT_MTIME_LO:    sel = RegTimeLo;
      CLINT_MTIME_HI:    sel = RegTimeHi;
      default:           sel = RegNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs.
//   clk      - destination clock
//   reset_n  - asynchronous active-low reset, clears both stages
//   d        - asynchronous input, WIDTH bits (each bit synchronized independently)
//   q        - synchronized output, valid two edges after d settles
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/clint_timer.sv
// clint_timer: machine-level interrupt source (mtime/mtimecmp, msip, MEIP sync).
//   Parameters:
//     TICK_DIV  - core clocks per mtime increment (1..65535)
//     BASE_ADDR - bus base address of the register block
//   Bus:
//     bus_valid/bus_we/bus_addr/bus_wdata - request (always accepted, bus_ready comb.)
//     bus_rvalid/bus_rdata                - read response, one cycle after acceptance
//   Interrupts:
//     ext_irq_async - asynchronous external interrupt level
//     irq_timer     - MTIP, registered (mtime >= mtimecmp)
//     irq_soft      - MSIP, msip[0]
//     irq_ext       - MEIP, synchronized ext_irq_async
//   mtime_out       - current mtime for time/timeh CSR reads
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        bus_ready,
  output logic        bus_rvalid,
  output logic [31:0] bus_rdata,
  input  logic        ext_irq_async,
  output logic        irq_timer,
  output logic        irq_soft,
  output logic        irq_ext,
  output logic [63:0] mtime_out
);

  localparam logic [15:0] DivLast = 16'(TICK_DIV - 1);

  // State
  logic [15:0] r_div_cnt;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic        r_irq_timer;
  logic        r_rvalid;
  logic [31:0] r_rdata;

  // Next-state / decode
  clint_reg_e  w_sel;
  logic        w_wr;
  logic        w_rd;
  logic        w_tick;
  logic [15:0] w_div_cnt_d;
  logic [63:0] w_mtime_d;
  logic [63:0] w_mtimecmp_d;
  logic        w_msip_d;
  logic [31:0] w_rdata_mux;

  assign w_sel = clint_decode(bus_addr, BASE_ADDR);
  assign w_wr  = bus_valid & bus_we;
  assign w_rd  = bus_valid & ~bus_we;

  // Prescaler: free-running, never disturbed by bus writes
  assign w_tick      = (r_div_cnt == DivLast);
  assign w_div_cnt_d = w_tick ? 16'd0 : r_div_cnt + 16'd1;

  // mtime: a write to either half wins over a coincident tick, and the other
  // half is frozen for that cycle so a software write never picks up a carry.
  always_comb begin
    w_mtime_d = r_mtime;
    if (w_wr && (w_sel == RegTimeLo)) begin
      w_mtime_d[31:0] = bus_wdata;
    end else if (w_wr && (w_sel == RegTimeHi)) begin
      w_mtime_d[63:32] = bus_wdata;
    end else if (w_tick) begin
      w_mtime_d = r_mtime + 64'd1;
    end
  end

  always_comb begin
    w_mtimecmp_d = r_mtimecmp;
    if (w_wr && (w_sel == RegCmpLo)) begin
      w_mtimecmp_d[31:0] = bus_wdata;
    end else if (w_wr && (w_sel == RegCmpHi)) begin
      w_mtimecmp_d[63:32] = bus_wdata;
    end
  end

  always_comb begin
    w_msip_d = r_msip;
    if (w_wr && (w_sel == RegMsip)) begin
      w_msip_d = bus_wdata[0];
    end
  end

  // Read mux samples pre-edge register values; unmapped offsets read 0
  always_comb begin
    w_rdata_mux = 32'd0;
    case (w_sel)
      RegMsip:   w_rdata_mux = {31'd0, r_msip};
      RegCmpLo:  w_rdata_mux = r_mtimecmp[31:0];
      RegCmpHi:  w_rdata_mux = r_mtimecmp[63:32];
      RegTimeLo: w_rdata_mux = r_mtime[31:0];
      RegTimeHi: w_rdata_mux = r_mtime[63:32];
      default:   w_rdata_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt   <= 16'd0;
      r_mtime     <= 64'd0;
      r_mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_msip      <= 1'b0;
      r_irq_timer <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= 32'd0;
    end else begin
      r_div_cnt   <= w_div_cnt_d;
      r_mtime     <= w_mtime_d;
      r_mtimecmp  <= w_mtimecmp_d;
      r_msip      <= w_msip_d;
      // Compare uses current register values: one cycle of latency, level output
      r_irq_timer <= (r_mtime >= r_mtimecmp);
      r_rvalid    <= w_rd;
      r_rdata     <= w_rd ? w_rdata_mux : 32'd0;
    end
  end

  sync_2ff #(
    .WIDTH(1)
  ) u_sync_ext (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (ext_irq_async),
    .q      (irq_ext)
  );

  // Gated by reset so the handshake is dead while reset is asserted
  assign bus_ready  = bus_valid & reset_n;
  assign bus_rvalid = r_rvalid;
  assign bus_rdata  = r_rdata;
  assign irq_timer  = r_irq_timer;
  assign irq_soft   = r_msip;
  assign mtime_out  = r_mtime;

endmodule

// File: doc/clint_timer.md
# clint_timer

Machine-level interrupt source for the core: a memory-mapped 64-bit `mtime`/`mtimecmp` timer, a software-interrupt register (`msip`), and a synchronizer for the external interrupt line. It sits on the data-bus side of the CPU and drives the pending bits (MTIP bit 7, MSIP bit 3, MEIP bit 11) that the CSR block latches into `mip` and arbitrates against `mie`/`mstatus.MIE`. It is the producer end of the interrupt interface the CSR block consumes.

## Interface
- `TICK_DIV`, default 1: core clocks per `mtime` increment, legal range 1..65535.
- `BASE_ADDR`, default 32'h0200_0000: bus base address; offsets below are relative to it.
- `clk` input 1: core clock.
- `reset_n` input 1: reset, asynchronous assert, active-low.
- `bus_valid` input 1: access request.
- `bus_we` input 1: 1 = write, 0 = read.
- `bus_addr` input 32: byte address, word-aligned.
- `bus_wdata` input 32: write data.
- `bus_ready` output 1: request accepted this cycle.
- `bus_rvalid` output 1: read data valid.
- `bus_rdata` output 32: read data.
- `ext_irq_async` input 1: external interrupt line, asynchronous level.
- `irq_timer` output 1: MTIP to the CSR block.
- `irq_soft` output 1: MSIP to the CSR block.
- `irq_ext` output 1: synchronized MEIP to the CSR block.
- `mtime_out` output 64: current `mtime`, for `time`/`timeh` CSR reads.

## Operation
- Register map, offsets from `BASE_ADDR`:
  - 0x0000 `msip`: only bit 0 is implemented, the rest read 0.
  - 0x4000 / 0x4004: `mtimecmp` lo / hi.
  - 0xBFF8 / 0xBFFC: `mtime` lo / hi.
  - Other offsets: reads return 0, writes are ignored, handshake is still completed.
- Prescaler: a 16-bit counter `div_cnt` counts 0..`TICK_DIV`-1. A tick fires on the cycle `div_cnt` == `TICK_DIV`-1, then the counter returns to 0. With `TICK_DIV`=1, every cycle ticks.
- On a tick, `mtime` increments as a full 64-bit add. The carry propagates lo→hi, and 2^64-1 wraps to 0.
- Write to an `mtime` half in the same cycle as a tick:
  - The written half takes `bus_wdata`.
  - The other half holds its value with no increment and no carry.
  - `div_cnt` is not disturbed.
- `irq_timer` is a register that loads (`mtime` >= `mtimecmp`), unsigned 64-bit, from the current register values every cycle. It is level-sensitive and clears only when software raises `mtimecmp` or writes `mtime`.
- `irq_soft` = `msip[0]`.
- `irq_ext`: 2-flop synchronizer on `ext_irq_async`, level pass-through with no latching.
- Reset values:
  - `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, `msip` = 0, `div_cnt` = 0.
  - Sync flops = 0.
  - `bus_ready` = 0, `bus_rvalid` = 0, `bus_rdata` = 0.
  - `irq_*` = 0.

## Timing
- Handshake:
  - `bus_ready` is high on the same cycle as `bus_valid`, combinational, when not in reset.
  - Writes take effect at the clock edge that accepts them.
  - A read is accepted at cycle N. `bus_rvalid` = 1 and `bus_rdata` holds the register value sampled at edge N during cycle N+1, for exactly one cycle.
  - Back-to-back reads are legal, one per cycle.
- `irq_timer` latency: 1 cycle after `mtime`/`mtimecmp` reach the compare condition.
- `irq_soft` latency: 1 cycle after the `msip` write edge.
- `irq_ext` latency: 2–3 edges after `ext_irq_async` changes.
- `mtime_out` is the register value with no extra latency.
- Read of `mtime` lo/hi is not atomic across halves. Software uses the hi-lo-hi loop. No shadow latching.
- Reset asserted mid-access: `bus_rvalid` drops immediately, no pending read survives, all state goes to reset values asynchronously.

## Structure
- A shared package `clint_pkg` holds:
  - offset constants `CLINT_MSIP`, `CLINT_MTIMECMP_LO/HI`, `CLINT_MTIME_LO/HI`;
  - `mip` bit indices `MIP_MSIP`=3, `MIP_MTIP`=7, `MIP_MEIP`=11, shared with the CSR block.
- One sub-module: `sync_2ff` (parameterized width, 2-flop synchronizer), used for `ext_irq_async` and reusable for later async inputs.
- Prescaler, timer, register file and bus logic stay in `clint_timer`.

## Test plan
- Reset, then hold: `mtime` = 0, `irq_timer` = 0 with `mtimecmp` = all-ones. After 10 cycles with `TICK_DIV`=1, a read of 0xBFF8 returns 10 with `bus_rvalid` one cycle after acceptance.
- Write `mtimecmp` hi = 0, then lo = 20 (`TICK_DIV`=1) → `irq_timer` rises the cycle after `mtime` reaches 20. Write `mtimecmp` lo = 1000 → `irq_timer` falls 1 cycle later.
- Write `mtime` lo = 32'hFFFF_FFFF, hi = 5 → after one tick, hi = 6 and lo = 0 (carry). Write hi = 32'hFFFF_FFFF, lo = 32'hFFFF_FFFF → next tick gives `mtime` = 0.
- `TICK_DIV`=4: `mtime` increments every 4th cycle. A write of 100 to lo on a tick cycle → lo reads 100, hi unchanged, next increment 4 cycles later.
- Write 1 to `msip` → `irq_soft` = 1 next cycle. Write 32'hFFFF_FFFE → `irq_soft` = 0, and a read returns 0.
- Pulse `ext_irq_async` high for 5 cycles → `irq_ext` high for 5 cycles, delayed 2 edges. Assert `reset_n` low mid-read → `bus_rvalid`, `irq_*` drop immediately.
